// File: rtl/decode_pkg.sv
// Shared types for the decode stage: RV64I opcodes, control bundle and the
// fetch/decode pipeline payloads.
package decode_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       wen;
    logic       word_op;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       illegal;
  } control_t;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   ra1;
    logic [RW-1:0]   ra2;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] imm;
    control_t        ctrl;
  } decode_data_t;

  // alt selects SUB/SRA; caller masks it where instr[30] is immediate data.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_decoder.sv
// Combinational RV64I decoder: instruction word to control bundle, immediate
// and source-register usage.
module decode_decoder
  import decode_pkg::*;
(
  input  logic [31:0]     instr,
  output control_t        ctrl,
  output logic [XLEN-1:0] imm,
  output logic            uses_rs1,
  output logic            uses_rs2
);
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       legal, writes;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    ctrl              = '0;
    ctrl.alu_op       = ALU_ADD;
    ctrl.mem_size     = f3[1:0];
    ctrl.mem_unsigned = f3[2];
    imm      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    writes   = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OP_LUI:   begin writes = 1'b1; imm = imm_u; ctrl.alu_op = ALU_PASSB; end
      OP_AUIPC: begin writes = 1'b1; imm = imm_u; end
      OP_JAL:   begin writes = 1'b1; imm = imm_j; ctrl.is_jump = 1'b1; end
      OP_JALR: begin
        writes = 1'b1; uses_rs1 = 1'b1; imm = imm_i; ctrl.is_jump = 1'b1;
        legal = (f3 == 3'b000);
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_b;
        ctrl.is_branch = 1'b1; ctrl.alu_op = ALU_SUB;
        legal = (f3[2:1] != 2'b01);
      end
      OP_LOAD: begin
        writes = 1'b1; uses_rs1 = 1'b1; imm = imm_i; ctrl.is_load = 1'b1;
        legal = (f3 != 3'b111);
      end
      OP_STORE: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_s; ctrl.is_store = 1'b1;
        legal = ~f3[2];
      end
      OP_IMM: begin
        writes = 1'b1; uses_rs1 = 1'b1; imm = imm_i;
        ctrl.alu_op = alu_decode(f3, instr[30] & (f3 == 3'b101));
        // 6-bit shamt on RV64, so only instr[31:26] is funct
        if (f3 == 3'b001)      legal = (instr[31:26] == 6'b000000);
        else if (f3 == 3'b101) legal = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
      end
      OP_OP: begin
        writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ctrl.alu_op = alu_decode(f3, instr[30]);
        legal = (f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101));
      end
      OP_IMM32: begin
        writes = 1'b1; uses_rs1 = 1'b1; imm = imm_i; ctrl.word_op = 1'b1;
        ctrl.alu_op = alu_decode(f3, instr[30] & (f3 == 3'b101));
        legal = (f3 == 3'b000) || ((f3 == 3'b001) && (f7 == 7'b0000000)) ||
                ((f3 == 3'b101) && (f7 == 7'b0000000 || f7 == 7'b0100000));
      end
      OP_OP32: begin
        writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; ctrl.word_op = 1'b1;
        ctrl.alu_op = alu_decode(f3, instr[30]);
        legal = ((f3 == 3'b000 || f3 == 3'b101) && (f7 == 7'b0000000 || f7 == 7'b0100000)) ||
                ((f3 == 3'b001) && (f7 == 7'b0000000));
      end
      default: legal = 1'b0;
    endcase
    // An illegal instruction has no side effects and never creates a hazard.
    if (!legal) begin
      ctrl.illegal  = 1'b1;
      ctrl.is_load  = 1'b0;
      ctrl.is_store = 1'b0;
      ctrl.is_branch = 1'b0;
      ctrl.is_jump  = 1'b0;
      writes   = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
    ctrl.wen = writes & (instr[11:7] != 5'd0);
  end
endmodule

// File: rtl/decode.sv
// Decode stage: register-file read, load-use hazard detection and the
// decode/execute pipeline register.
module decode
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  fetch_data_t     dataF,
  input  logic            branch,
  input  logic            stop,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [RW-1:0]   ex_rd,
  output logic [RW-1:0]   ra1,
  output logic [RW-1:0]   ra2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  output logic            stall_req,
  output decode_data_t    dataD
);
  control_t        ctrl;
  logic [XLEN-1:0] imm;
  logic            uses_rs1, uses_rs2, hazard;

  decode_decoder u_dec (
    .instr    (dataF.instr),
    .ctrl     (ctrl),
    .imm      (imm),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign ra1 = uses_rs1 ? dataF.instr[19:15] : '0;
  assign ra2 = uses_rs2 ? dataF.instr[24:20] : '0;

  assign hazard = dataF.valid & ex_valid & ex_is_load & (ex_rd != '0) &
                  ((uses_rs1 & (ra1 == ex_rd)) | (uses_rs2 & (ra2 == ex_rd)));

  assign stall_req = reset & hazard & ~branch & ~stop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dataD <= '0;
    end else if (branch) begin
      dataD.valid <= 1'b0;
    end else if (stop) begin
      dataD <= dataD;
    end else if (hazard) begin
      dataD.valid <= 1'b0;
    end else begin
      dataD.valid <= dataF.valid;
      dataD.pc    <= dataF.pc;
      dataD.instr <= dataF.instr;
      dataD.rd    <= dataF.instr[11:7];
      dataD.ra1   <= ra1;
      dataD.ra2   <= ra2;
      dataD.src1  <= rd1;
      dataD.src2  <= rd2;
      dataD.imm   <= imm;
      dataD.ctrl  <= ctrl;
    end
  end
endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode stage.
module tb_decode;
  import decode_pkg::*;

  logic            clk = 1'b0;
  logic            reset, branch, stop, ex_valid, ex_is_load, stall_req;
  logic [RW-1:0]   ex_rd, ra1, ra2;
  logic [XLEN-1:0] rd1, rd2;
  fetch_data_t     dataF;
  decode_data_t    dataD;
  int total = 0;
  int bad   = 0;

  decode dut (
    .clk(clk), .reset(reset), .dataF(dataF), .branch(branch), .stop(stop),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .stall_req(stall_req), .dataD(dataD)
  );

  always #5 clk = ~clk;

  // Register file stand-in: x0 reads zero, xN reads 0x1000+N.
  always_comb rd1 = (ra1 == '0) ? '0 : 64'h1000 + 64'(ra1);
  always_comb rd2 = (ra2 == '0) ? '0 : 64'h1000 + 64'(ra2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] instr, input logic [63:0] pc);
    dataF.valid = 1'b1;
    dataF.instr = instr;
    dataF.pc    = pc;
    #1;
  endtask

  initial begin
    reset = 1'b0; branch = 1'b0; stop = 1'b0;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
    // add x2,x5,x0 would hazard if reset did not mask it
    feed(32'h00028133, 64'h80000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_zero", 64'(dataD == '0), 64'd1);
      chk("rst_stall", 64'(stall_req), 64'd0);
    end

    reset = 1'b1; ex_valid = 1'b0;
    feed(32'h00500093, 64'h80000000);   // addi x1,x0,5
    tick();
    chk("addi_valid", 64'(dataD.valid), 64'd1);
    chk("addi_rd", 64'(dataD.rd), 64'd1);
    chk("addi_imm", dataD.imm, 64'd5);
    chk("addi_wen", 64'(dataD.ctrl.wen), 64'd1);
    chk("addi_ra1", 64'(dataD.ra1), 64'd0);
    chk("addi_illegal", 64'(dataD.ctrl.illegal), 64'd0);
    chk("addi_pc", dataD.pc, 64'h80000000);
    chk("addi_src1", dataD.src1, 64'd0);

    // Load-use on x5
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
    feed(32'h00028133, 64'h80000004);
    chk("lu_ra1", 64'(ra1), 64'd5);
    chk("lu_stall", 64'(stall_req), 64'd1);
    tick();
    chk("lu_bubble", 64'(dataD.valid), 64'd0);
    chk("lu_stall_hold", 64'(stall_req), 64'd1);
    ex_valid = 1'b0; #1;
    chk("lu_release", 64'(stall_req), 64'd0);
    tick();
    chk("add_valid", 64'(dataD.valid), 64'd1);
    chk("add_rd", 64'(dataD.rd), 64'd2);
    chk("add_src1", dataD.src1, 64'h1005);
    chk("add_alu", 64'(dataD.ctrl.alu_op), 64'(ALU_ADD));

    // Stop holds the register while fetch changes
    stop = 1'b1;
    feed(32'h00500093, 64'h80000008);
    tick();
    chk("stop1_instr", 64'(dataD.instr), 64'h00028133);
    feed(32'h00108013, 64'h8000000C);
    tick();
    chk("stop2_instr", 64'(dataD.instr), 64'h00028133);
    chk("stop2_valid", 64'(dataD.valid), 64'd1);
    branch = 1'b1;
    tick();
    chk("br_stop_valid", 64'(dataD.valid), 64'd0);

    // Branch beats a simultaneous load-use hazard
    branch = 1'b0; stop = 1'b0;
    feed(32'h00500093, 64'h80000010);
    tick();
    chk("pre_br_valid", 64'(dataD.valid), 64'd1);
    ex_valid = 1'b1; branch = 1'b1;
    feed(32'h00028133, 64'h80000014);
    chk("br_haz_stall", 64'(stall_req), 64'd0);
    tick();
    chk("br_haz_valid", 64'(dataD.valid), 64'd0);

    // Unsupported opcode: no hazard even though rs fields match ex_rd
    branch = 1'b0; ex_rd = 5'd31;
    feed(32'hFFFFFFFF, 64'h80000018);
    chk("ill_stall", 64'(stall_req), 64'd0);
    tick();
    chk("ill_valid", 64'(dataD.valid), 64'd1);
    chk("ill_flag", 64'(dataD.ctrl.illegal), 64'd1);
    chk("ill_wen", 64'(dataD.ctrl.wen), 64'd0);
    ex_valid = 1'b0;

    feed(32'h00108013, 64'h8000001C);   // addi x0,x1,1
    tick();
    chk("x0_wen", 64'(dataD.ctrl.wen), 64'd0);
    chk("x0_ra1", 64'(dataD.ra1), 64'd1);
    chk("x0_src1", dataD.src1, 64'h1001);

    feed(32'hFE000EE3, 64'h80000020);   // beq x0,x0,-4
    tick();
    chk("beq_imm", dataD.imm, 64'hFFFFFFFFFFFFFFFC);
    chk("beq_branch", 64'(dataD.ctrl.is_branch), 64'd1);
    chk("beq_wen", 64'(dataD.ctrl.wen), 64'd0);

    feed(32'h800001B7, 64'h80000024);   // lui x3,0x80000
    tick();
    chk("lui_imm", dataD.imm, 64'hFFFFFFFF80000000);
    chk("lui_wen", 64'(dataD.ctrl.wen), 64'd1);

    feed(32'hFE20BC23, 64'h80000028);   // sd x2,-8(x1)
    tick();
    chk("sd_imm", dataD.imm, 64'hFFFFFFFFFFFFFFF8);
    chk("sd_ra2", 64'(dataD.ra2), 64'd2);
    chk("sd_src2", dataD.src2, 64'h1002);
    chk("sd_size", 64'(dataD.ctrl.mem_size), 64'd3);
    chk("sd_store", 64'(dataD.ctrl.is_store), 64'd1);

    feed(32'h0010D01B, 64'h8000002C);   // srliw x0 form, legal word op
    tick();
    chk("srliw_word", 64'(dataD.ctrl.word_op), 64'd1);
    chk("srliw_illegal", 64'(dataD.ctrl.illegal), 64'd0);

    feed(32'h02208033, 64'h80000030);   // mul encoding: not RV64I
    tick();
    chk("mul_illegal", 64'(dataD.ctrl.illegal), 64'd1);

    dataF.valid = 1'b0;
    tick();
    chk("invalid_bubble", 64'(dataD.valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode.md
Name: decode

Overview:
- Decode stage, directly downstream of instruction fetch.
- Consumes fetch_data_t (valid, instr, pc) and decodes RV64I instructions into control signals and a sign-extended immediate.
- Drives register-file read addresses and captures the read data.
- Registers the result into decode_data_t for execute, detects load-use hazards (raising a stall back to fetch) and handles flush and downstream stall.

Parameters:
XLEN, 64, datapath width; pc, immediate and operands are XLEN bits.
NREG, 32, architectural register count; register index width is log2(NREG)=5.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous active-low reset (asserted when 0).
dataF  input  fetch_data_t  instruction from fetch: valid, instr[31:0], pc[63:0].
branch  input  1  redirect from execute; flushes this stage.
stop  input  1  downstream stall; hold output register.
ex_valid  input  1  execute stage holds a valid instruction.
ex_is_load  input  1  execute instruction is a load.
ex_rd  input  5  execute destination register.
ra1  output  5  regfile read address 1 (combinational).
ra2  output  5  regfile read address 2 (combinational).
rd1  input  64  regfile read data 1 (same cycle).
rd2  input  64  regfile read data 2 (same cycle).
stall_req  output  1  load-use stall to fetch (combinational).
dataD  output  decode_data_t  registered decoded instruction.

Behaviour:
- Reset: reset==0 at posedge sets dataD to all zeros (valid=0). stall_req is 0 while reset==0.
- Latency: one cycle from dataF to dataD.
- Combinational decode of opcode instr[6:0]:
  - Supported: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32.
  - Anything else sets ctrl.illegal=1 and wen=0; uses_rs1=uses_rs2=0 for these.
  - Illegal funct3/funct7 combinations within a supported opcode also set illegal.
- Immediates: I/S/B/U/J formats, sign-extended from instr[31] to 64 bits. B and J have bit0=0. U imm = {sext(instr[31:12]),12'b0}.
- Read addresses:
  - ra1=instr[19:15] when uses_rs1, else 0.
  - ra2=instr[24:20] when uses_rs2 (BRANCH, STORE, OP, OP-32), else 0.
- Destination: wen=1 only for instructions that write rd and rd!=0; rd=0 forces wen=0.
- ctrl.word_op=1 for OP-IMM-32/OP-32. mem_size=funct3[1:0]. mem_unsigned=funct3[2].
- Hazard = dataF.valid & ex_valid & ex_is_load & ex_rd!=0 & ((uses_rs1 & ra1==ex_rd) | (uses_rs2 & ra2==ex_rd)).
- stall_req = hazard & ~branch & ~stop.
- Output register update priority, highest first:
  1. reset==0: clear.
  2. branch: dataD.valid<=0; other fields don't-care.
  3. stop: hold all fields.
  4. hazard: bubble, dataD.valid<=0.
  5. Otherwise: load decode result, dataD.valid<=dataF.valid.
- Invalid dataF (valid=0) never raises hazard and loads a bubble.
- Hazard persists until execute no longer holds the load. Fetch holds dataF (via stop) for the duration, so the same instruction is re-evaluated each cycle.
- No forwarding in this block; src1/src2 are raw regfile data, and x0 reads return 0 from the regfile.

Decomposition:
- pipes package:
  - decode_data_t: valid, pc, instr, rd, ra1, ra2, src1, src2, imm, ctrl.
  - control_t: alu_op, is_load, is_store, is_branch, is_jump, wen, word_op, mem_size, mem_unsigned, illegal.
  - alu_op_t enum.
- common package: opcode localparams (OP_LUI=7'b0110111, etc.).
- One sub-module, decoder: purely combinational, instr -> control_t, imm, uses_rs1, uses_rs2. The decode module owns hazard logic and the pipeline register.

Test Plan:
- Hold reset=0 for 3 cycles with dataF.valid=1 -> dataD.valid=0, all fields 0, stall_req=0. Release -> first valid dataD one cycle later.
- dataF {valid=1, instr=0x00500093 (addi x1,x0,5), pc=0x80000000} -> next cycle dataD: valid=1, rd=1, imm=5, wen=1, ra1=0, illegal=0.
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=5; dataF instr=0x00028133 (add x2,x5,x0):
  - stall_req=1 and dataD.valid=0 next cycle.
  - Drop ex_valid -> stall_req=0 and dataD loads add.
- Stop held 2 cycles while dataF changes -> dataD unchanged both cycles. Branch asserted with stop=1 -> dataD.valid=0 next cycle.
- Branch=1 coinciding with a load-use hazard -> stall_req=0 and dataD.valid=0.
- Edge cases:
  - instr=0xFFFFFFFF -> illegal=1, wen=0, stall_req=0.
  - addi x0,x1,1 -> wen=0.
  - beq imm=-4 (0xFE000EE3) -> imm=0xFFFFFFFFFFFFFFFC.
